// File: rtl/sipo_pkg.sv
// Shared types and constants for the sipo_deser serial-to-parallel deserialiser.
package sipo_pkg;

    // Receive FSM: DATA collects word bits, PAR samples the trailing parity bit.
    typedef enum logic [0:0] {
        DATA = 1'b0,
        PAR  = 1'b1
    } sipo_state_t;

    // Default word width.
    localparam int unsigned SIPO_N_DEF = 8;

endpackage

// File: rtl/sipo_shift.sv
// Shift register and bit counter for sipo_deser. Assembles serial bits in the
// configured order and strobes when the N-th bit of a word is sampled.
module sipo_shift
    import sipo_pkg::*;
#(
    parameter int unsigned N         = SIPO_N_DEF,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk_i,
    input  logic         n_res_i,
    input  logic         shift_en_i,
    input  logic         clr_i,
    input  logic         sin_i,
    output logic [N-1:0] sr_o,
    output logic [N-1:0] word_o,
    output logic         done_o
);

    localparam int unsigned     CntW   = $clog2(N);
    localparam logic [CntW-1:0] CntMax = CntW'(N - 1);

    logic [N-1:0]    sr_q, sr_d;
    logic [N-1:0]    sr_shift;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            done;

    // Order selection: MSB-first pushes in at bit 0 so the first bit ends up on top.
    if (MSB_FIRST) begin : g_msb_first
        assign sr_shift = {sr_q[N-2:0], sin_i};
    end else begin : g_lsb_first
        assign sr_shift = {sin_i, sr_q[N-1:1]};
    end

    // Next-state for shift register and counter; clr beats a same-edge shift.
    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        done  = 1'b0;
        if (clr_i) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (shift_en_i) begin
            sr_d = sr_shift;
            if (cnt_q == CntMax) begin
                cnt_d = '0;
                done  = 1'b1;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!n_res_i) begin
            sr_q  <= '0;
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign sr_o   = sr_q;
    // Word including the bit sampled on this edge, valid when done_o is high.
    assign word_o = sr_shift;
    assign done_o = done;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserialiser with registered valid/ready output.
// Optional trailing even-parity check enabled by defining SIPO_DESER_PARITY_EN.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int unsigned N         = SIPO_N_DEF,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         n_res,
    input  logic         sin,
    input  logic         sin_en,
    input  logic         clr,
    input  logic         q_ready,
    output logic [N-1:0] Q,
    output logic         q_valid,
    output logic         overrun,
    output logic         par_err
);

    logic         shift_en;
    logic [N-1:0] sr;
    logic [N-1:0] word_shift;
    logic         word_done;
    logic         deliver;
    logic [N-1:0] deliver_word;

    logic [N-1:0] q_q, q_d;
    logic         valid_q, valid_d;
    logic         overrun_q, overrun_d;

    sipo_shift #(
        .N         (N),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk_i      (clk),
        .n_res_i    (n_res),
        .shift_en_i (shift_en),
        .clr_i      (clr),
        .sin_i      (sin),
        .sr_o       (sr),
        .word_o     (word_shift),
        .done_o     (word_done)
    );

`ifdef SIPO_DESER_PARITY_EN
    sipo_state_t state_q, state_d;
    logic        par_err_q, par_err_d;

    // Bits only enter the shift register while collecting data; in PAR the
    // completed word sits untouched in sr.
    assign shift_en     = sin_en & (state_q == DATA);
    assign deliver_word = sr;

    // FSM next-state and parity decision.
    always_comb begin
        state_d   = state_q;
        par_err_d = 1'b0;
        deliver   = 1'b0;
        if (clr) begin
            state_d = DATA;
        end else begin
            unique case (state_q)
                DATA: begin
                    if (word_done) state_d = PAR;
                end
                PAR: begin
                    if (sin_en) begin
                        state_d = DATA;
                        if ((^sr ^ sin) == 1'b0) deliver = 1'b1;
                        else                     par_err_d = 1'b1;
                    end
                end
                default: state_d = DATA;
            endcase
        end
    end

    // FSM state and parity-error pulse register.
    always_ff @(posedge clk) begin
        if (!n_res) begin
            state_q   <= DATA;
            par_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            par_err_q <= par_err_d;
        end
    end

    assign par_err = par_err_q;

    // The in-flight shifted word is not needed: delivery waits for the parity edge.
    logic unused_word_shift;
    assign unused_word_shift = ^word_shift;
`else
    assign shift_en     = sin_en;
    assign deliver      = word_done;
    assign deliver_word = word_shift;
    assign par_err      = 1'b0;

    logic unused_sr;
    assign unused_sr = ^sr;
`endif

    // Holding register: load on delivery if empty or being drained, else flag overrun.
    always_comb begin
        q_d       = q_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (valid_q && q_ready) valid_d = 1'b0;
        if (deliver) begin
            if (!valid_q || q_ready) begin
                q_d     = deliver_word;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (clr) overrun_d = 1'b0;
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (!n_res) begin
            q_q       <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign Q       = q_q;
    assign q_valid = valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: one MSB-first and one LSB-first instance share the same
// serial stream; a bit-queue reference model predicts every output each cycle.
module tb_sipo_deser;

    localparam int N = 8;

    logic         clk = 1'b0;
    logic         n_res, sin, sin_en, clr, q_ready;
    logic [N-1:0] q_m, q_l;
    logic         v_m, v_l, o_m, o_l, p_m, p_l;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit           m_bits[$];
    bit           m_par_wait;
    logic [N-1:0] m_pend_m, m_pend_l;
    logic [N-1:0] m_qm, m_ql;
    logic         m_valid, m_over, m_perr;

    always #5 clk = ~clk;

    sipo_deser #(.N(N), .MSB_FIRST(1'b1)) u_msb (
        .clk     (clk),
        .n_res   (n_res),
        .sin     (sin),
        .sin_en  (sin_en),
        .clr     (clr),
        .q_ready (q_ready),
        .Q       (q_m),
        .q_valid (v_m),
        .overrun (o_m),
        .par_err (p_m)
    );

    sipo_deser #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
        .clk     (clk),
        .n_res   (n_res),
        .sin     (sin),
        .sin_en  (sin_en),
        .clr     (clr),
        .q_ready (q_ready),
        .Q       (q_l),
        .q_valid (v_l),
        .overrun (o_l),
        .par_err (p_l)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model one clock edge from the currently applied inputs.
    task automatic model_edge();
        bit           deliver = 1'b0;
        bit           perr = 1'b0;
        logic [N-1:0] wm, wl;
        if (!n_res) begin
            m_bits.delete();
            m_par_wait = 1'b0;
            m_qm = '0; m_ql = '0;
            m_valid = 1'b0; m_over = 1'b0; m_perr = 1'b0;
            return;
        end
        wm = m_pend_m;
        wl = m_pend_l;
        if (clr) begin
            m_bits.delete();
            m_par_wait = 1'b0;
        end else if (sin_en) begin
            if (m_par_wait) begin
                m_par_wait = 1'b0;
                if ((^m_pend_m ^ sin) == 1'b0) deliver = 1'b1;
                else                           perr = 1'b1;
            end else begin
                m_bits.push_back(sin);
                if (m_bits.size() == N) begin
                    for (int i = 0; i < N; i++) begin
                        wm[N-1-i] = m_bits[i];
                        wl[i]     = m_bits[i];
                    end
                    m_bits.delete();
`ifdef SIPO_DESER_PARITY_EN
                    m_par_wait = 1'b1;
                    m_pend_m   = wm;
                    m_pend_l   = wl;
`else
                    deliver = 1'b1;
`endif
                end
            end
        end
        if (deliver) begin
            if (!m_valid || q_ready) begin
                m_qm = wm; m_ql = wl; m_valid = 1'b1;
            end else begin
                m_over = 1'b1;
            end
        end else if (m_valid && q_ready) begin
            m_valid = 1'b0;
        end
        if (clr) m_over = 1'b0;
        m_perr = perr;
    endtask

    task automatic step(input logic r, input logic s, input logic se, input logic c,
                        input logic qr);
        n_res = r; sin = s; sin_en = se; clr = c; q_ready = qr;
        @(posedge clk);
        model_edge();
        #1;
        chk("q_msb", q_m, m_qm);
        chk("q_lsb", q_l, m_ql);
        chk("flags_msb", {v_m, o_m, p_m}, {m_valid, m_over, m_perr});
        chk("flags_lsb", {v_l, o_l, p_l}, {m_valid, m_over, m_perr});
    endtask

    // Send bits seq[N-1] first; parity bit appended when compiled in.
    task automatic send_seq(input logic [N-1:0] seq, input logic par, input logic qr_last);
        logic qr;
        for (int i = N - 1; i >= 0; i--) begin
            qr = 1'b0;
`ifndef SIPO_DESER_PARITY_EN
            if (i == 0) qr = qr_last;
`endif
            step(1'b1, seq[i], 1'b1, 1'b0, qr);
        end
`ifdef SIPO_DESER_PARITY_EN
        step(1'b1, par, 1'b1, 1'b0, qr_last);
`else
        if (par) ; // unused without parity
`endif
    endtask

    task automatic idle(input logic qr);
        step(1'b1, 1'($urandom), 1'b0, 1'b0, qr);
    endtask

    initial begin
        m_pend_m = '0; m_pend_l = '0;
        m_bits.delete();
        m_par_wait = 1'b0;
        m_qm = '0; m_ql = '0; m_valid = 1'b0; m_over = 1'b0; m_perr = 1'b0;

        // Reset
        step(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        step(1'b0, 1'($urandom), 1'($urandom), 1'b0, 1'b0);
        chk("reset_q", q_m, 32'h0);
        chk("reset_flags", {v_m, o_m, p_m}, 3'b000);

        // First word held without ready
        send_seq(8'hAA, 1'b0, 1'b0);
        chk("first_q_msb", q_m, 32'hAA);
        chk("first_q_lsb", q_l, 32'h55);
        chk("first_valid", v_m, 1'b1);
        for (int i = 0; i < 5; i++) idle(1'b0);
        chk("first_hold_q", q_m, 32'hAA);
        chk("first_hold_valid", v_m, 1'b1);

        // Consume and next word
        idle(1'b1);
        chk("consume_valid", v_m, 1'b0);
        send_seq(8'h55, 1'b0, 1'b0);
        chk("second_q_msb", q_m, 32'h55);
        chk("second_q_lsb", q_l, 32'hAA);

        // Overrun
        idle(1'b1);
        send_seq(8'hAA, 1'b0, 1'b0);
        send_seq(8'h55, 1'b0, 1'b0);
        chk("ovr_q_kept", q_m, 32'hAA);
        chk("ovr_flag", o_m, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("clr_ovr", o_m, 1'b0);
        chk("clr_valid_kept", v_m, 1'b1);
        send_seq(8'h55, 1'b0, 1'b1);
        chk("b2b_q", q_m, 32'h55);
        chk("b2b_valid", v_m, 1'b1);
        chk("b2b_no_ovr", o_m, 1'b0);

        // Interrupted by reset
        idle(1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        send_seq(8'h55, 1'b0, 1'b0);
        chk("intr_rst_q", q_m, 32'h55);

        // Interrupted by clr with a same-edge bit
        idle(1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        send_seq(8'h55, 1'b0, 1'b0);
        chk("intr_clr_q", q_m, 32'h55);
        chk("intr_clr_valid", v_m, 1'b1);

`ifdef SIPO_DESER_PARITY_EN
        idle(1'b1);
        send_seq(8'hAA, 1'b0, 1'b0);
        chk("par_ok_q", q_m, 32'hAA);
        chk("par_ok_perr", p_m, 1'b0);
        idle(1'b1);
        send_seq(8'h55, 1'b1, 1'b0);
        chk("par_bad_perr", p_m, 1'b1);
        chk("par_bad_valid", v_m, 1'b0);
        idle(1'b0);
        chk("par_pulse_end", p_m, 1'b0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(99) != 0),
                 1'($urandom),
                 ($urandom_range(9) < 7),
                 ($urandom_range(39) == 0),
                 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
